// File: rtl/systolic_feeder.sv
// systolic_feeder: diagonal-skew read sequencer between the 4x4 operand
// memory and the systolic array input edge. Line c lags line c-1 by one
// cycle; captured lanes are registered with per-lane valids.
module systolic_feeder #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stall,
    output logic [3:0]                read_enable,
    output logic [7:0]                read_elem,
    input  logic [4*DATA_WIDTH-1:0]   mem_data,
    output logic [4*DATA_WIDTH-1:0]   array_data,
    output logic [3:0]                array_valid,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DRAIN
    } state_t;

    state_t     state;
    logic [2:0] step;

    // Memory read port decoded purely from state/step: lane c active for step in [c, c+3].
    always_comb begin
        read_enable = '0;
        read_elem   = '0;
        if (state == FEED) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if ((32'(step) >= c) && (32'(step) <= c + 3)) begin
                    read_enable[c]     = 1'b1;
                    read_elem[2*c +: 2] = 2'(32'(step) - c);
                end
            end
        end
    end

    // Busy covers the whole feed including the drain cycle.
    always_comb begin
        busy = (state != IDLE);
    end

    // Sequencer FSM with registered lane capture and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            step        <= '0;
            array_data  <= '0;
            array_valid <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    array_valid <= '0;
                    if (start) begin
                        state <= FEED;
                        step  <= '0;
                    end
                end
                FEED: begin
                    if (stall) begin
                        array_valid <= '0;
                    end else begin
                        for (int unsigned c = 0; c < 4; c++) begin
                            array_data[c*DATA_WIDTH +: DATA_WIDTH] <=
                                read_enable[c] ? mem_data[c*DATA_WIDTH +: DATA_WIDTH] : '0;
                        end
                        array_valid <= read_enable;
                        if (step == 3'd6) begin
                            state <= DRAIN;
                        end else begin
                            step <= step + 3'd1;
                        end
                    end
                end
                DRAIN: begin
                    array_valid <= '0;
                    if (!stall) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: an asynchronous 4x4 memory model,
// a feed-progress reference model, directed scenarios and a random phase.
module tb_systolic_feeder;

    localparam int DW = 8;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            start = 1'b0;
    logic            stall = 1'b0;
    logic [3:0]      read_enable;
    logic [7:0]      read_elem;
    logic [4*DW-1:0] mem_data;
    logic [4*DW-1:0] array_data;
    logic [3:0]      array_valid;
    logic            busy;
    logic            done;

    logic [DW-1:0]   mem [4][4];

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    systolic_feeder #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .read_enable (read_enable),
        .read_elem   (read_elem),
        .mem_data    (mem_data),
        .array_data  (array_data),
        .array_valid (array_valid),
        .busy        (busy),
        .done        (done)
    );

    // Asynchronous-read operand memory.
    always_comb begin
        mem_data = '0;
        for (int c = 0; c < 4; c++) begin
            mem_data[c*DW +: DW] = mem[c][read_elem[2*c +: 2]];
        end
    end

    // Reference model: m_k counts non-stalled feed edges since start (0..6 feeding, 7 = draining).
    logic            m_ready = 1'b0;
    logic            m_active;
    int              m_k;
    logic [3:0]      m_valid;
    logic [4*DW-1:0] m_data;
    logic            m_done;

    function automatic bit lane_on(int k, int c);
        return (k >= c) && (k <= c + 3);
    endfunction

    function automatic logic [3:0] exp_re();
        logic [3:0] r = '0;
        for (int c = 0; c < 4; c++) begin
            if (m_active && m_k <= 6 && lane_on(m_k, c)) r[c] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_rel();
        logic [7:0] r = '0;
        for (int c = 0; c < 4; c++) begin
            if (m_active && m_k <= 6 && lane_on(m_k, c)) r[2*c +: 2] = 2'(m_k - c);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (rst) begin
            m_ready  <= 1'b1;
            m_active <= 1'b0;
            m_k      <= 0;
            m_valid  <= '0;
            m_data   <= '0;
        end else if (!m_active) begin
            m_valid <= '0;
            if (start) begin
                m_active <= 1'b1;
                m_k      <= 0;
            end
        end else if (m_k <= 6) begin
            if (stall) begin
                m_valid <= '0;
            end else begin
                for (int c = 0; c < 4; c++) begin
                    if (lane_on(m_k, c)) begin
                        m_valid[c]         <= 1'b1;
                        m_data[c*DW +: DW] <= mem[c][m_k - c];
                    end else begin
                        m_valid[c]         <= 1'b0;
                        m_data[c*DW +: DW] <= '0;
                    end
                end
                m_k <= m_k + 1;
            end
        end else begin
            m_valid <= '0;
            if (!stall) begin
                m_active <= 1'b0;
                m_done   <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_valid", 32'(array_valid), 32'(m_valid));
            chk("model_data",  32'(array_data),  32'(m_data));
            chk("model_busy",  32'(busy),        32'(m_active));
            chk("model_done",  32'(done),        32'(m_done));
            chk("model_re",    32'(read_enable), 32'(exp_re()));
            chk("model_rel",   32'(read_elem),   32'(exp_rel()));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic tk(inout int nb, inout int nd);
        @(negedge clk);
        nb += int'(busy);
        nd += int'(done);
    endtask

    task automatic set_ramp();
        for (int l = 0; l < 4; l++)
            for (int e = 0; e < 4; e++)
                mem[l][e] = DW'(16 * l + e);
    endtask

    logic [3:0] vseq [8];
    int nb, nd, n;

    initial begin
        vseq[0] = 4'b0001; vseq[1] = 4'b0011; vseq[2] = 4'b0111; vseq[3] = 4'b1111;
        vseq[4] = 4'b1110; vseq[5] = 4'b1100; vseq[6] = 4'b1000; vseq[7] = 4'b0000;
        for (int l = 0; l < 4; l++)
            for (int e = 0; e < 4; e++)
                mem[l][e] = DW'($urandom);

        // Reset state
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("rst_valid", 32'(array_valid), 32'h0);
        chk("rst_data",  32'(array_data),  32'h0);
        chk("rst_busy",  32'(busy),        32'h0);
        chk("rst_done",  32'(done),        32'h0);
        chk("rst_re",    32'(read_enable), 32'h0);
        tick();

        // Basic feed with ramp contents
        set_ramp();
        start = 1'b1; tick(); start = 1'b0;
        nb = int'(busy); nd = int'(done);
        for (int i = 1; i <= 9; i++) begin
            tk(nb, nd);
            if (i <= 8) chk("basic_valid_seq", 32'(array_valid), 32'(vseq[i-1]));
            if (i <= 4) chk("basic_lane0", 32'(array_data[7:0]), 32'(i - 1));
            if (i >= 4 && i <= 7) chk("basic_lane3", 32'(array_data[31:24]), 32'h30 + 32'(i - 4));
            if (i == 8) chk("basic_done_cycle", 32'(done), 32'h1);
        end
        chk("basic_busy_cycles", 32'(nb), 32'd8);
        chk("basic_done_count",  32'(nd), 32'd1);

        // Stall for two cycles at step 3
        start = 1'b1; tick(); start = 1'b0;
        nb = int'(busy); nd = 0;
        repeat (3) tk(nb, nd);
        stall = 1'b1;
        chk("stall_rel_pre", 32'(read_elem), 32'h1B);
        repeat (2) begin
            tk(nb, nd);
            chk("stall_valid", 32'(array_valid), 32'h0);
            chk("stall_rel",   32'(read_elem),   32'h1B);
            chk("stall_hold",  32'(array_data[7:0]), 32'h02);
        end
        stall = 1'b0;
        tk(nb, nd);
        chk("stall_resume1", 32'(array_valid), 32'hF);
        chk("stall_lane0",   32'(array_data[7:0]), 32'h03);
        chk("stall_lane3",   32'(array_data[31:24]), 32'h30);
        tk(nb, nd);
        chk("stall_resume2", 32'(array_valid), 32'hE);
        repeat (6) tk(nb, nd);
        chk("stall_busy_cycles", 32'(nb), 32'd10);
        chk("stall_done_count",  32'(nd), 32'd1);

        // Start re-pulsed at step 2 and during DRAIN
        start = 1'b1; tick(); start = 1'b0;
        nb = 0; nd = 0;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        chk("drain_busy", 32'(busy), 32'h1);
        start = 1'b1; tk(nb, nd); start = 1'b0;
        repeat (15) tk(nb, nd);
        chk("rebusy_done_count", 32'(nd), 32'd1);
        chk("rebusy_idle", 32'(busy), 32'h0);

        // Back-to-back tiles
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!done && n < 30) begin tick(); n++; end
        chk("b2b_first_done", 32'(done), 32'h1);
        start = 1'b1; tick(); start = 1'b0;
        chk("b2b_re", 32'(read_enable), 32'h1);
        n = 1;
        while (!done && n < 30) begin tick(); n++; end
        chk("b2b_spacing", 32'(n), 32'd9);
        tick();

        // Reset at step 4
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_valid", 32'(array_valid), 32'h0);
        chk("midrst_data",  32'(array_data),  32'h0);
        chk("midrst_re",    32'(read_enable), 32'h0);
        chk("midrst_rel",   32'(read_elem),   32'h0);
        chk("midrst_busy",  32'(busy),        32'h0);
        nb = 0; nd = int'(done);
        repeat (12) tk(nb, nd);
        chk("midrst_no_done", 32'(nd), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        nb = int'(busy); nd = 0;
        repeat (10) tk(nb, nd);
        chk("postrst_busy", 32'(nb), 32'd8);
        chk("postrst_done", 32'(nd), 32'd1);

        // Stall held in IDLE while start pulses
        stall = 1'b1; start = 1'b1; tick(); start = 1'b0;
        chk("idlestall_busy", 32'(busy), 32'h1);
        chk("idlestall_re",   32'(read_enable), 32'h1);
        tick(); tick();
        chk("idlestall_frozen", 32'(array_valid), 32'h0);
        stall = 1'b0; tick();
        chk("idlestall_valid", 32'(array_valid), 32'h1);
        chk("idlestall_lane0", 32'(array_data[7:0]), 32'h00);
        repeat (10) tick();

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(3) == 0);
            stall = ($urandom_range(3) == 0);
            rst   = ($urandom_range(99) == 0);
            mem[$urandom_range(3)][$urandom_range(3)] = DW'($urandom);
            tick();
        end
        start = 1'b0; stall = 1'b0; rst = 1'b0;
        repeat (12) tick();
        chk("final_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
